regfile_wb_arbiter: RTL and testbench

//  Shares the single register-file write port between the in-order pipeline WB stage and the

---
 rtl/regfile_wb_arbiter.sv | 157 +++++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
//   Shares the single register-file write port between the in-order pipeline WB stage and the
//   multi-cycle MUL/DIV unit. MUL/DIV results are buffered in a small FIFO and written in cycles
//   with no pipeline write. If the pipeline keeps winning while the FIFO holds data, a one-cycle
//   pipeline stall is forced so the FIFO head can drain.
//
// Ports
//   clk, rst              clock; synchronous active-high reset
//   wb_valid/rd/data      pipeline WB result (rd==0 is never written)
//   md_valid/rd/data      MUL/DIV result offer; md_ready is the FIFO accept
//   stall_pipe            registered; pipeline holds its WB inputs while high
//   rf_we/rf_rd/rf_wdata  register-file write port (combinational)
//   md_count              FIFO occupancy

module regfile_wb_arbiter #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wb_valid,
  input  logic [4:0]               wb_rd,
  input  logic [XLEN-1:0]          wb_data,
  input  logic                     md_valid,
  input  logic [4:0]               md_rd,
  input  logic [XLEN-1:0]          md_data,
  output logic                     md_ready,
  output logic                     stall_pipe,
  output logic                     rf_we,
  output logic [4:0]               rf_rd,
  output logic [XLEN-1:0]          rf_wdata,
  output logic [$clog2(DEPTH):0]   md_count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned StvW = $clog2(STARVE_MAX + 1);

  typedef enum logic [0:0] {StNormal, StForce} state_e;

  state_e          state_q, state_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic [StvW-1:0] starve_q, starve_d;
  logic [StvW-1:0] starve_inc;

  // FIFO storage needs no reset: occupancy is tracked by count_q alone.
  logic [4:0]      mem_rd   [DEPTH];
  logic [XLEN-1:0] mem_data [DEPTH];

  logic fifo_empty;
  logic pipe_req;
  logic accept;
  logic push;
  logic pop;

  assign fifo_empty = (count_q == '0);
  assign stall_pipe = (state_q == StForce);
  assign pipe_req   = wb_valid && !stall_pipe && (wb_rd != 5'd0);
  assign md_ready   = !rst && (count_q < CntW'(DEPTH));
  assign accept     = md_valid && md_ready;
  // Results targeting x0 are accepted from MUL/DIV but never stored.
  assign push       = accept && (md_rd != 5'd0);
  assign starve_inc = starve_q + StvW'(1);
  assign md_count   = count_q;

  // Arbitration and FSM next state
  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    pop      = 1'b0;
    rf_we    = 1'b0;
    rf_rd    = 5'd0;
    rf_wdata = '0;

    unique case (state_q)
      StNormal: begin
        if (pipe_req) begin
          rf_we    = 1'b1;
          rf_rd    = wb_rd;
          rf_wdata = wb_data;
          if (!fifo_empty) begin
            if (starve_inc == StvW'(STARVE_MAX)) begin
              state_d  = StForce;
              starve_d = '0;
            end else begin
              starve_d = starve_inc;
            end
          end
        end else if (!fifo_empty) begin
          rf_we    = 1'b1;
          rf_rd    = mem_rd[rd_ptr_q];
          rf_wdata = mem_data[rd_ptr_q];
          pop      = 1'b1;
          starve_d = '0;
        end
      end
      StForce: begin
        // WB inputs are ignored here; the pipeline re-presents them next cycle.
        if (!fifo_empty) begin
          rf_we    = 1'b1;
          rf_rd    = mem_rd[rd_ptr_q];
          rf_wdata = mem_data[rd_ptr_q];
          pop      = 1'b1;
        end
        starve_d = '0;
        state_d  = StNormal;
      end
      default: state_d = StNormal;
    endcase

    if (rst) begin
      rf_we = 1'b0;
      pop   = 1'b0;
    end
  end

  // FIFO pointer and occupancy next state
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PtrW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    count_d = count_q + CntW'(push) - CntW'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StNormal;
      starve_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_rd[wr_ptr_q]   <= md_rd;
      mem_data[wr_ptr_q] <= md_data;
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;

  logic        clk;
  logic        rst;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        md_valid;
  logic [4:0]  md_rd;
  logic [31:0] md_data;
  logic        md_ready;
  logic        stall_pipe;
  logic        rf_we;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wdata;
  logic [2:0]  md_count;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        stall;
  } exp_t;

  exp_t exp_q[$];

  regfile_wb_arbiter #(
    .XLEN      (32),
    .DEPTH     (4),
    .STARVE_MAX(8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .wb_valid  (wb_valid),
    .wb_rd     (wb_rd),
    .wb_data   (wb_data),
    .md_valid  (md_valid),
    .md_rd     (md_rd),
    .md_data   (md_data),
    .md_ready  (md_ready),
    .stall_pipe(stall_pipe),
    .rf_we     (rf_we),
    .rf_rd     (rf_rd),
    .rf_wdata  (rf_wdata),
    .md_count  (md_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every register-file write must match the next expected write in order.
  always @(negedge clk) begin
    exp_t e;
    if (rf_we) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got rd=%0d data=%h expected no write at %0t",
                 rf_rd, rf_wdata, $time);
      end else begin
        e = exp_q.pop_front();
        chk("wr_rd", 32'(rf_rd), 32'(e.rd));
        chk("wr_data", rf_wdata, e.data);
        chk("wr_stall", 32'(stall_pipe), 32'(e.stall));
      end
    end else if (stall_pipe) begin
      chk("stall_without_write", 32'(stall_pipe), 32'd0);
    end
  end

  task automatic drive(input logic wv, input logic [4:0] wr, input logic [31:0] wd,
                       input logic mv, input logic [4:0] mr, input logic [31:0] md);
    wb_valid = wv;
    wb_rd    = wr;
    wb_data  = wd;
    md_valid = mv;
    md_rd    = mr;
    md_data  = md;
  endtask

  task automatic expect_wr(input logic [4:0] rd, input logic [31:0] data, input logic stall);
    exp_t e;
    e.rd    = rd;
    e.data  = data;
    e.stall = stall;
    exp_q.push_back(e);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 32'hDEAD_BEEF);

    // 1: reset with md_valid asserted
    for (int i = 0; i < 2; i++) begin
      next_cycle();
      @(negedge clk);
      chk("rst_md_ready", 32'(md_ready), 32'd0);
      chk("rst_rf_we", 32'(rf_we), 32'd0);
      chk("rst_md_count", 32'(md_count), 32'd0);
      chk("rst_stall", 32'(stall_pipe), 32'd0);
    end
    next_cycle();
    rst = 1'b0;

    // 2: idle drain
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'h0000_1234);
    @(negedge clk);
    chk("idle_md_ready", 32'(md_ready), 32'd1);
    next_cycle();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    expect_wr(5'd5, 32'h0000_1234, 1'b0);
    next_cycle();
    @(negedge clk);
    chk("idle_count", 32'(md_count), 32'd0);

    // 3: contention, forced drain after 8 pipeline wins
    next_cycle();
    drive(1'b1, 5'd3, 32'hA000_0000, 1'b1, 5'd7, 32'h0000_0077);
    expect_wr(5'd3, 32'hA000_0000, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      next_cycle();
      drive(1'b1, 5'd3, 32'hA000_0000 + 32'(k), 1'b0, 5'd0, 32'd0);
      expect_wr(5'd3, 32'hA000_0000 + 32'(k), 1'b0);
    end
    next_cycle();
    drive(1'b1, 5'd3, 32'hA000_0009, 1'b0, 5'd0, 32'd0);
    expect_wr(5'd7, 32'h0000_0077, 1'b1);
    @(negedge clk);
    chk("force_stall", 32'(stall_pipe), 32'd1);
    next_cycle();
    expect_wr(5'd3, 32'hA000_0009, 1'b0);
    @(negedge clk);
    chk("force_release", 32'(stall_pipe), 32'd0);
    next_cycle();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    @(negedge clk);
    chk("contention_count", 32'(md_count), 32'd0);

    // 4: FIFO full, fifth result held until a pop frees a slot
    for (int k = 0; k < 4; k++) begin
      next_cycle();
      drive(1'b1, 5'd3, 32'hB000_0000 + 32'(k), 1'b1, 5'(10 + k), 32'hC000_0000 + 32'(k));
      expect_wr(5'd3, 32'hB000_0000 + 32'(k), 1'b0);
    end
    next_cycle();
    drive(1'b1, 5'd3, 32'hB000_0004, 1'b1, 5'd14, 32'hC000_0004);
    expect_wr(5'd3, 32'hB000_0004, 1'b0);
    @(negedge clk);
    chk("full_count", 32'(md_count), 32'd4);
    chk("full_ready", 32'(md_ready), 32'd0);
    next_cycle();
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd14, 32'hC000_0004);
    expect_wr(5'd10, 32'hC000_0000, 1'b0);
    @(negedge clk);
    chk("full_ready_pop", 32'(md_ready), 32'd0);
    next_cycle();
    expect_wr(5'd11, 32'hC000_0001, 1'b0);
    @(negedge clk);
    chk("full_ready_freed", 32'(md_ready), 32'd1);
    chk("full_count_3", 32'(md_count), 32'd3);
    next_cycle();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    expect_wr(5'd12, 32'hC000_0002, 1'b0);
    next_cycle();
    expect_wr(5'd13, 32'hC000_0003, 1'b0);
    next_cycle();
    expect_wr(5'd14, 32'hC000_0004, 1'b0);
    next_cycle();
    @(negedge clk);
    chk("full_drained", 32'(md_count), 32'd0);

    // 5: wb_rd==0 lets the FIFO head through; md_rd==0 is dropped
    next_cycle();
    drive(1'b1, 5'd3, 32'hD000_0000, 1'b1, 5'd9, 32'h0000_0999);
    expect_wr(5'd3, 32'hD000_0000, 1'b0);
    next_cycle();
    drive(1'b1, 5'd0, 32'hD000_0001, 1'b1, 5'd0, 32'h0BAD_0BAD);
    expect_wr(5'd9, 32'h0000_0999, 1'b0);
    @(negedge clk);
    chk("x0_ready", 32'(md_ready), 32'd1);
    next_cycle();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    @(negedge clk);
    chk("x0_count", 32'(md_count), 32'd0);
    next_cycle();

    // 6: reset mid-operation discards buffered results
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 5'd3, 32'hE000_0000 + 32'(k), 1'b1, 5'(20 + k), 32'hF000_0000 + 32'(k));
      expect_wr(5'd3, 32'hE000_0000 + 32'(k), 1'b0);
      next_cycle();
    end
    drive(1'b1, 5'd3, 32'hE000_0003, 1'b0, 5'd0, 32'd0);
    expect_wr(5'd3, 32'hE000_0003, 1'b0);
    @(negedge clk);
    chk("midrst_count_3", 32'(md_count), 32'd3);
    next_cycle();
    rst = 1'b1;
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd6, 32'h0000_0666);
    @(negedge clk);
    chk("midrst_ready", 32'(md_ready), 32'd0);
    next_cycle();
    rst = 1'b0;
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    @(negedge clk);
    chk("midrst_count_0", 32'(md_count), 32'd0);
    chk("midrst_stall", 32'(stall_pipe), 32'd0);
    for (int i = 0; i < 4; i++) begin
      next_cycle();
    end
    @(negedge clk);
    #1;
    chk("all_writes_seen", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
